// File: rtl/rom2r_rr_arbiter.sv
// rom2r_rr_arbiter
//   Round-robin arbiter that shares the two read ports of a dual-read
//   synchronous LUT ROM among NUM_REQ requesters. Up to two grants per cycle
//   (port A = first eligible from rr_ptr, port B = second). A registered tag
//   per port follows the ROM's 1-cycle read latency. The returned word is
//   captured into a per-requester response slot, so a request in cycle T
//   gives rsp_valid from cycle T+2.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid/req_addr     per-requester request strobe and address
//                          (requester i at [i*ADDR_WIDTH +: ADDR_WIDTH])
//   req_ready              combinational grant, one bit per requester
//   rsp_valid/rsp_data     per-requester response, held until rsp_ready
//   rsp_ready              per-requester response consume
//   rom_addr_a/b           ROM read addresses (0 when the port is idle)
//   rom_dout_a/b           ROM read data, one cycle after the address
//   stat_grants/stalls     only when ROM2R_ARB_STATS_EN is defined:
//                          saturating grant count and stall-cycle count
//
// Optional macro: ROM2R_ARB_STATS_EN

// Per-requester response slot: owns busy plus the held response word.
module rom2r_rsp_slot #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  gnt,
  input  logic                  cap,
  input  logic [DATA_WIDTH-1:0] cap_data,
  input  logic                  rsp_ready,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  busy
);
  logic hs;
  assign hs = rsp_valid && rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      // A grant in the handshake cycle keeps busy set (same-cycle reuse).
      if (gnt)     busy <= 1'b1;
      else if (hs) busy <= 1'b0;
      // busy guarantees a capture never lands on an unconsumed word.
      if (cap) begin
        rsp_valid <= 1'b1;
        rsp_data  <= cap_data;
      end else if (hs) begin
        rsp_valid <= 1'b0;
      end
    end
  end
endmodule

module rom2r_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [NUM_REQ*DATA_WIDTH-1:0] rsp_data,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic [ADDR_WIDTH-1:0]         rom_addr_a,
  output logic [ADDR_WIDTH-1:0]         rom_addr_b,
  input  logic [DATA_WIDTH-1:0]         rom_dout_a,
  input  logic [DATA_WIDTH-1:0]         rom_dout_b
`ifdef ROM2R_ARB_STATS_EN
  ,
  output logic [31:0]                   stat_grants,
  output logic [31:0]                   stat_stalls
`endif
);
  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]   rr_ptr, rr_nxt;
  logic [NUM_REQ-1:0] busy, eligible, gnt;
  logic               a_vld, b_vld;
  logic [PTR_W-1:0]   a_idx, b_idx;
  logic               tag_a_vld, tag_b_vld;
  logic [PTR_W-1:0]   tag_a_idx, tag_b_idx;

  function automatic logic [PTR_W-1:0] inc_wrap(input logic [PTR_W-1:0] v);
    inc_wrap = (v == PTR_W'(NUM_REQ-1)) ? '0 : v + 1'b1;
  endfunction

  // Gating with rst_n keeps req_ready low while reset is held.
  assign eligible = req_valid & (~busy | (rsp_valid & rsp_ready)) & {NUM_REQ{rst_n}};

  // Scan from rr_ptr: first eligible -> port A, second -> port B.
  always_comb begin
    a_vld = 1'b0;
    b_vld = 1'b0;
    a_idx = '0;
    b_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      automatic int j = (int'(rr_ptr) + k) % NUM_REQ;
      if (eligible[j]) begin
        if (!a_vld) begin
          a_vld = 1'b1;
          a_idx = PTR_W'(j);
        end else if (!b_vld) begin
          b_vld = 1'b1;
          b_idx = PTR_W'(j);
        end
      end
    end
  end

  // B is always later in scan order than A, so it is the last grantee.
  always_comb begin
    rr_nxt = rr_ptr;
    if (b_vld)      rr_nxt = inc_wrap(b_idx);
    else if (a_vld) rr_nxt = inc_wrap(a_idx);
  end

  assign rom_addr_a = a_vld ? req_addr[a_idx*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign rom_addr_b = b_vld ? req_addr[b_idx*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign req_ready  = gnt;

  // Tags line up with rom_dout_a/b one cycle after the grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      tag_a_vld <= 1'b0;
      tag_b_vld <= 1'b0;
      tag_a_idx <= '0;
      tag_b_idx <= '0;
    end else begin
      rr_ptr    <= rr_nxt;
      tag_a_vld <= a_vld;
      tag_b_vld <= b_vld;
      tag_a_idx <= a_idx;
      tag_b_idx <= b_idx;
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    logic cap_a, cap_b;
    assign gnt[i] = (a_vld && a_idx == PTR_W'(i)) || (b_vld && b_idx == PTR_W'(i));
    assign cap_a  = tag_a_vld && tag_a_idx == PTR_W'(i);
    assign cap_b  = tag_b_vld && tag_b_idx == PTR_W'(i);

    rom2r_rsp_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .gnt       (gnt[i]),
      .cap       (cap_a || cap_b),
      .cap_data  (cap_a ? rom_dout_a : rom_dout_b),
      .rsp_ready (rsp_ready[i]),
      .rsp_valid (rsp_valid[i]),
      .rsp_data  (rsp_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .busy      (busy[i])
    );
  end

`ifdef ROM2R_ARB_STATS_EN
  logic [32:0] grants_sum, stalls_sum;
  assign grants_sum = {1'b0, stat_grants} + 33'(a_vld) + 33'(b_vld);
  assign stalls_sum = {1'b0, stat_stalls} + 33'(|(req_valid & ~gnt));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_grants <= '0;
      stat_stalls <= '0;
    end else begin
      stat_grants <= grants_sum[32] ? '1 : grants_sum[31:0];
      stat_stalls <= stalls_sum[32] ? '1 : stalls_sum[31:0];
    end
  end
`endif
endmodule

// File: tb/tb_rom2r_rr_arbiter.sv
// Directed bench for rom2r_rr_arbiter (NUM_REQ=4, ADDR=10, DATA=32) with a
// behavioural synchronous dual-read ROM.
module tb_rom2r_rr_arbiter;
  localparam int NR = 4, AW = 10, DW = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  rsp_data;
  logic [AW-1:0]     rom_addr_a, rom_addr_b;
  logic [DW-1:0]     rom_dout_a = '0, rom_dout_b = '0;
`ifdef ROM2R_ARB_STATS_EN
  logic [31:0]       stat_grants, stat_stalls;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rom2r_rr_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_ready  (rsp_ready),
    .rom_addr_a (rom_addr_a),
    .rom_addr_b (rom_addr_b),
    .rom_dout_a (rom_dout_a),
    .rom_dout_b (rom_dout_b)
`ifdef ROM2R_ARB_STATS_EN
    ,
    .stat_grants(stat_grants),
    .stat_stalls(stat_stalls)
`endif
  );

  // ROM contents: a distinctive word per address.
  function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
    rom_f = {a, 2'b01, ~a, 10'h2A5};
  endfunction

  always @(posedge clk) begin
    rom_dout_a <= rom_f(rom_addr_a);
    rom_dout_b <= rom_f(rom_addr_b);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    req_addr[i*AW +: AW] = a;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; rsp_ready = '0;
    #1;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = '0; req_addr = '0; rsp_ready = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_rsp_data", 64'(|rsp_data), 64'h0);
    req_valid = 4'hF; #1;
    chk("rst_req_ready", 64'(req_ready), 64'h0);
    req_valid = '0; rst_n = 1'b1; #1;

    // Single requester, latency 2, port B idle
    set_addr(0, 10'h005); req_valid = 4'b0001; #1;
    chk("s1_ready", 64'(req_ready), 64'h1);
    chk("s1_addr_a", 64'(rom_addr_a), 64'h005);
    chk("s1_addr_b", 64'(rom_addr_b), 64'h000);
    tick(); req_valid = '0; #1;
    chk("s1_t1_valid", 64'(rsp_valid), 64'h0);
    tick();
    chk("s1_t2_valid", 64'(rsp_valid), 64'h1);
    chk("s1_t2_data", 64'(rsp_data[0*DW +: DW]), 64'(rom_f(10'h005)));
    rsp_ready = 4'b0001;
    tick();
    chk("s1_clear", 64'(rsp_valid), 64'h0);

    // All four requesters, full throughput
    do_reset();
    for (int i = 0; i < NR; i++) set_addr(i, AW'(10'h010 + i));
    req_valid = 4'hF; rsp_ready = 4'hF; #1;
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("s2_c%0d_ready", c), 64'(req_ready), (c % 2 == 0) ? 64'h3 : 64'hC);
      chk($sformatf("s2_c%0d_addr_a", c), 64'(rom_addr_a), (c % 2 == 0) ? 64'h010 : 64'h012);
      chk($sformatf("s2_c%0d_addr_b", c), 64'(rom_addr_b), (c % 2 == 0) ? 64'h011 : 64'h013);
      if (c >= 2) begin
        chk($sformatf("s2_c%0d_rsp_valid", c), 64'(rsp_valid), (c % 2 == 0) ? 64'h3 : 64'hC);
        if (c % 2 == 0) begin
          chk($sformatf("s2_c%0d_d0", c), 64'(rsp_data[0*DW +: DW]), 64'(rom_f(10'h010)));
          chk($sformatf("s2_c%0d_d1", c), 64'(rsp_data[1*DW +: DW]), 64'(rom_f(10'h011)));
        end else begin
          chk($sformatf("s2_c%0d_d2", c), 64'(rsp_data[2*DW +: DW]), 64'(rom_f(10'h012)));
          chk($sformatf("s2_c%0d_d3", c), 64'(rsp_data[3*DW +: DW]), 64'(rom_f(10'h013)));
        end
      end else begin
        chk($sformatf("s2_c%0d_rsp_valid", c), 64'(rsp_valid), 64'h0);
      end
      tick();
    end
`ifdef ROM2R_ARB_STATS_EN
    chk("s2_stat_grants", 64'(stat_grants), 64'd20);
    chk("s2_stat_stalls", 64'(stat_stalls), 64'd10);
`endif
    req_valid = '0;
    repeat (3) tick();
    chk("s2_drained", 64'(rsp_valid), 64'h0);

    // Backpressured requester 2 is not regranted until it consumes
    do_reset();
    set_addr(2, 10'h020); req_valid = 4'b0100; #1;
    chk("s3_grant", 64'(req_ready), 64'h4);
    chk("s3_grant_addr", 64'(rom_addr_a), 64'h020);
    tick();
    chk("s3_busy_ready", 64'(req_ready), 64'h0);
    tick();
    chk("s3_rsp_valid", 64'(rsp_valid), 64'h4);
    chk("s3_rsp_data", 64'(rsp_data[2*DW +: DW]), 64'(rom_f(10'h020)));
    set_addr(2, 10'h021); #1;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("s3_hold%0d_ready", c), 64'(req_ready), 64'h0);
      chk($sformatf("s3_hold%0d_valid", c), 64'(rsp_valid), 64'h4);
      chk($sformatf("s3_hold%0d_data", c), 64'(rsp_data[2*DW +: DW]), 64'(rom_f(10'h020)));
      tick();
    end
    rsp_ready = 4'b0100; #1;
    chk("s3_regrant", 64'(req_ready), 64'h4);
    chk("s3_regrant_addr", 64'(rom_addr_a), 64'h021);
    tick(); req_valid = '0; #1;
    chk("s3_after_hs", 64'(rsp_valid), 64'h0);
    tick();
    chk("s3_rsp2_valid", 64'(rsp_valid), 64'h4);
    chk("s3_rsp2_data", 64'(rsp_data[2*DW +: DW]), 64'(rom_f(10'h021)));

    // Same address on both ports
    do_reset();
    set_addr(1, 10'h3FF); set_addr(3, 10'h3FF); req_valid = 4'b1010; #1;
    chk("s4_ready", 64'(req_ready), 64'hA);
    chk("s4_addr_a", 64'(rom_addr_a), 64'h3FF);
    chk("s4_addr_b", 64'(rom_addr_b), 64'h3FF);
    tick(); req_valid = '0;
    tick();
    chk("s4_rsp_valid", 64'(rsp_valid), 64'hA);
    chk("s4_d1", 64'(rsp_data[1*DW +: DW]), 64'(rom_f(10'h3FF)));
    chk("s4_d3", 64'(rsp_data[3*DW +: DW]), 64'(rom_f(10'h3FF)));

    // Reset with a read in flight
    do_reset();
    set_addr(2, 10'h030); req_valid = 4'b0100; #1;
    chk("s5_grant", 64'(req_ready), 64'h4);
    tick();
    rst_n = 1'b0; #1;
    chk("s5_rst_ready", 64'(req_ready), 64'h0);
    tick(); tick();
    rst_n = 1'b1; req_valid = '0; #1;
    chk("s5_post0_valid", 64'(rsp_valid), 64'h0);
    tick();
    chk("s5_post1_valid", 64'(rsp_valid), 64'h0);
    tick();
    chk("s5_post2_valid", 64'(rsp_valid), 64'h0);
    // rr_ptr back at 0: requester 0 outranks requester 3
    set_addr(0, 10'h005); set_addr(3, 10'h007); req_valid = 4'b1001; #1;
    chk("s5_ready", 64'(req_ready), 64'h9);
    chk("s5_addr_a", 64'(rom_addr_a), 64'h005);
    chk("s5_addr_b", 64'(rom_addr_b), 64'h007);
    tick(); req_valid = '0;
    tick();
    chk("s5_rsp_valid", 64'(rsp_valid), 64'h9);
    chk("s5_d0", 64'(rsp_data[0*DW +: DW]), 64'(rom_f(10'h005)));
    chk("s5_d3", 64'(rsp_data[3*DW +: DW]), 64'(rom_f(10'h007)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rom2r_rr_arbiter.md
Name: rom2r_rr_arbiter

Overview:
- Round-robin arbiter that shares the two read ports of the dual-read synchronous LUT ROM among NUM_REQ independent requesters.
- Grants up to two requests per cycle, one on port A and one on port B.
- Tracks the ROM's 1-cycle read latency and returns each word to its requester through a registered valid/ready response channel.
- Sits between the LUT consumers (NCO/interpolators) and the ROM instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_WIDTH, 10, ROM address width
DATA_WIDTH, 32, ROM word width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request strobe
req_addr  in  NUM_REQ*ADDR_WIDTH  per-requester address, requester i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
req_ready  out  NUM_REQ  request accepted this cycle (combinational)
rsp_valid  out  NUM_REQ  response word held for requester i
rsp_data  out  NUM_REQ*DATA_WIDTH  per-requester response word
rsp_ready  in  NUM_REQ  requester consumes response
rom_addr_a  out  ADDR_WIDTH  to ROM addr_a (combinational)
rom_addr_b  out  ADDR_WIDTH  to ROM addr_b (combinational)
rom_dout_a  in  DATA_WIDTH  from ROM dout_a
rom_dout_b  in  DATA_WIDTH  from ROM dout_b

Behaviour:
- Reset (async, rst_n=0): rsp_valid=0, rsp_data=0, busy[]=0, rr_ptr=0, in-flight tags invalid. In-flight reads are discarded. req_ready=0 while in reset.
- Eligibility: eligible[i] = req_valid[i] && (!busy[i] || (rsp_valid[i] && rsp_ready[i])).
- busy[i] is set on grant and cleared on the rsp_valid&&rsp_ready handshake.
- Arbitration: scan indices rr_ptr, rr_ptr+1, ... mod NUM_REQ. The first eligible requester gets port A; the second eligible gets port B.
- req_ready[i]=1 exactly for granted requesters.
- rr_ptr update: advances to (last granted index + 1) mod NUM_REQ; unchanged if nothing is granted.
- ROM addresses: rom_addr_a = req_addr of the port-A grantee, else 0; rom_addr_b likewise for port B.
- Tag pipeline: registered tag_a/tag_b hold {valid, index} for one cycle, aligned with rom_dout_a/b.
- Latency: grant in cycle T → ROM samples at the end of T → dout valid in T+1 → captured into rsp_data[idx] at the end of T+1 → rsp_valid high from T+2. Fixed 2-cycle request-to-response latency.
- Response hold: rsp_valid/rsp_data hold until rsp_ready. A new capture for the same index only occurs after a handshake, guaranteed by busy.
- Same-cycle reuse: a requester whose response handshakes in cycle T may be granted again in T. Sustained rate per requester is one request every 2 cycles; the aggregate ROM rate is 2 reads/cycle.
- Single eligible requester: gets port A only; port B stays idle at address 0.
- Equal addresses on A and B are legal; there is no coalescing.
- req_addr is sampled only in the grant cycle.

Optional Feature:
ROM2R_ARB_STATS_EN
- Defined:
  - Adds outputs stat_grants (32b, counts total grants, +2 when both ports grant) and stat_stalls (32b, counts cycles in which some req_valid is high but not granted).
  - Both counters saturate at 0xFFFFFFFF and reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then req_valid=4'b0001, addr0=0x005 → rom_addr_a=0x005 in T, req_ready=0001; rsp_valid[0]=1 at T+2 with ROM[5]; rsp_ready=1 clears it.
- All four requesters hold valid with addrs 0x010..0x013 and rsp_ready=1 → cycle 0 grants 0,1 (A,B), cycle 1 grants 2,3, cycle 2 grants 0,1. Each requester receives a response every 2 cycles with the correct words.
- Requester 2 with rsp_ready=0 and req_valid held → never re-granted while rsp_valid[2]=1; rsp_data[2] stable. Raise rsp_ready → regrant in the same cycle.
- Requesters 1 and 3 request the same address 0x3FF → both granted the same cycle on A and B; both receive ROM[0x3FF].
- Assert rst_n=0 one cycle after a grant → rsp_valid stays 0 after release; rr_ptr=0; the first post-reset request to requester 0 behaves as in scenario 1.
- With ROM2R_ARB_STATS_EN, run scenario 2 for 10 cycles → stat_grants=20, stat_stalls=10.
